// File: rtl/mel_fbank_seq.sv
// mel_fbank_seq: sequences STFT bins into the mel filterbank accumulator, adding per-bin weights and MAC toggles.
// A toggle request that cannot be shown in its own cycle is registered into mac_q and shown in the next cycle.
module mel_fbank_seq #(
    parameter int WIDTH = 16,
    parameter int N_FFT = 512,
    parameter int IDX_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stft_bin_vld,
    input  logic [WIDTH-1:0]     stft_bin,
    input  logic [IDX_W-1:0]     stft_bin_idx,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [2*WIDTH+1:0]   cfg_wdata,
    output logic                 out_bin_vld,
    output logic [WIDTH-1:0]     out_bin,
    output logic [IDX_W-1:0]     out_bin_idx,
    output logic [2*WIDTH-1:0]   mel_fbank_weight,
    output logic [1:0]           mac_bits,
    output logic                 frame_done,
    output logic                 seq_err,
    output logic                 cfg_err
);
    localparam int N_BINS = N_FFT / 2 + 1;
    localparam int EW = 2 * WIDTH + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH_A, FLUSH_B} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem [N_BINS];
    logic [EW-1:0]     rd_q;
    logic              vld_q;
    logic [WIDTH-1:0]  bin_q;
    logic [IDX_W-1:0]  idx_q, exp_q, exp_d;
    logic [1:0]        mac_q, mac_d, vtog, rtog;
    logic              last_q, last_d, cur_last;
    logic              done_q, serr_q, cerr_q;
    logic              f1, f2, dbl, accept, wr_en;

    assign f1 = rd_q[EW-1];
    assign f2 = rd_q[EW-2];
    // Both flags on the shown bin: MAC2 waits a cycle, and that cycle accepts no bin.
    assign dbl = vld_q & f1 & f2;
    assign accept = stft_bin_vld & (state_q == IDLE || state_q == RUN) & (stft_bin_idx == exp_q) & ~dbl;
    assign wr_en = cfg_we & (state_q == IDLE) & (cfg_addr <= LAST_IDX) & ~accept;

    // last_q: 1 = MAC1 was toggled most recently, 0 = MAC2
    assign vtog = vld_q ? {f1, f2 & ~f1} : 2'b00;
    assign cur_last = vtog[1] | (~vtog[0] & last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = (accept && stft_bin_idx == LAST_IDX) ? FLUSH_A : RUN;
            FLUSH_A: state_d = dbl ? FLUSH_A : FLUSH_B;
            default: state_d = IDLE;
        endcase
    end

    // Each flush closes the filter on the MAC that did not toggle last.
    always_comb begin
        rtog = dbl ? 2'b01 : (state_q == FLUSH_A || state_q == FLUSH_B) ? (cur_last ? 2'b01 : 2'b10) : 2'b00;
        mac_d = mac_bits ^ rtog;
        last_d = rtog[1] | (~rtog[0] & cur_last);
        exp_d = accept ? exp_q + 1'b1 : (state_q == FLUSH_B) ? '0 : exp_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            vld_q  <= 1'b0;
            bin_q  <= '0;
            idx_q  <= '0;
            exp_q  <= '0;
            mac_q  <= 2'b01;
            last_q <= 1'b0;
            done_q <= 1'b0;
            serr_q <= 1'b0;
            cerr_q <= 1'b0;
        end else begin
            vld_q <= accept;
            if (accept) begin
                rd_q  <= mem[stft_bin_idx];
                bin_q <= stft_bin;
                idx_q <= stft_bin_idx;
            end
            exp_q  <= exp_d;
            mac_q  <= mac_d;
            last_q <= last_d;
            done_q <= (state_q == FLUSH_B);
            serr_q <= (stft_bin_vld & ~accept) | dbl;
            cerr_q <= cfg_we & ~wr_en;
        end
    end

    assign out_bin_vld = vld_q;
    assign out_bin = bin_q;
    assign out_bin_idx = idx_q;
    assign mel_fbank_weight = rd_q[2*WIDTH-1:0];
    assign mac_bits = mac_q ^ vtog;
    assign frame_done = done_q;
    assign seq_err = serr_q;
    assign cfg_err = cerr_q;
endmodule

// File: tb/tb_mel_fbank_seq.sv
// tb_mel_fbank_seq: randomized and directed stimulus against a toggle-queue reference model of mel_fbank_seq.
// The model treats deferred and flush toggles as a queue of non-bin cycles that block input.
module tb_mel_fbank_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stft_bin_vld = 1'b0;
    logic [15:0] stft_bin = '0;
    logic [8:0]  stft_bin_idx = '0;
    logic        cfg_we = 1'b0;
    logic [8:0]  cfg_addr = '0;
    logic [33:0] cfg_wdata = '0;
    logic        out_bin_vld;
    logic [15:0] out_bin;
    logic [8:0]  out_bin_idx;
    logic [31:0] mel_fbank_weight;
    logic [1:0]  mac_bits;
    logic        frame_done, seq_err, cfg_err;

    mel_fbank_seq dut (
        .clk(clk), .rst_n(rst_n),
        .stft_bin_vld(stft_bin_vld), .stft_bin(stft_bin), .stft_bin_idx(stft_bin_idx),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_bin_vld(out_bin_vld), .out_bin(out_bin), .out_bin_idx(out_bin_idx),
        .mel_fbank_weight(mel_fbank_weight), .mac_bits(mac_bits),
        .frame_done(frame_done), .seq_err(seq_err), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: expected outputs for the cycle after each edge.
    logic        m_vld, m_fd, m_se, m_ce;
    logic [15:0] m_bin;
    logic [8:0]  m_idx, m_exp;
    logic [31:0] m_w;
    logic [1:0]  m_mac;
    int          m_last;
    int          tq[$];
    logic [33:0] tbl [257];
    logic        acc;
    logic [33:0] ent;
    int          k;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_vld = 0; m_bin = 0; m_idx = 0; m_w = 0; m_mac = 2'b01; m_last = 2;
            m_exp = 0; m_fd = 0; m_se = 0; m_ce = 0;
            tq.delete();
        end else begin
            acc = stft_bin_vld && tq.size() == 0 && stft_bin_idx == m_exp;
            m_vld = acc;
            m_fd = 0;
            m_se = stft_bin_vld && !acc;
            m_ce = cfg_we && !(tq.size() == 0 && m_exp == 0 && int'(cfg_addr) < 257 && !acc);
            if (cfg_we && !m_ce) tbl[cfg_addr] = cfg_wdata;
            if (tq.size() != 0) begin
                k = tq.pop_front();
                if (k == 1) begin
                    m_mac[0] = ~m_mac[0]; m_last = 2; m_se = 1;
                end else begin
                    if (m_last == 1) begin m_mac[0] = ~m_mac[0]; m_last = 2; end
                    else begin m_mac[1] = ~m_mac[1]; m_last = 1; end
                    m_fd = (k == 3);
                end
            end else if (acc) begin
                ent = tbl[stft_bin_idx];
                m_bin = stft_bin; m_idx = stft_bin_idx; m_w = ent[31:0];
                if (ent[33]) begin
                    m_mac[1] = ~m_mac[1]; m_last = 1;
                    if (ent[32]) tq.push_back(1);
                end else if (ent[32]) begin
                    m_mac[0] = ~m_mac[0]; m_last = 2;
                end
                if (stft_bin_idx == 9'd256) begin
                    tq.push_back(2); tq.push_back(3); m_exp = 0;
                end else m_exp = stft_bin_idx + 9'd1;
            end
        end
    end

    logic [1:0]  snap_mac [257];
    logic [31:0] snap_w [257];
    logic [1:0]  prev_mac = 2'b01;
    logic [1:0]  fd_mac = 2'b00;
    logic        prev_ok = 1'b0;
    int          fd_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {out_bin_vld, out_bin, out_bin_idx, mel_fbank_weight, mac_bits, frame_done, seq_err, cfg_err},
                {1'b0, 16'h0, 9'h0, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0});
        end else begin
            chk("out_bin_vld", out_bin_vld, m_vld);
            chk("out_bin", out_bin, m_bin);
            chk("out_bin_idx", out_bin_idx, m_idx);
            chk("weight", mel_fbank_weight, m_w);
            chk("mac_bits", mac_bits, m_mac);
            chk("frame_done", frame_done, m_fd);
            chk("seq_err", seq_err, m_se);
            chk("cfg_err", cfg_err, m_ce);
            if (prev_ok) chk("one_mac_change", 64'($countones(mac_bits ^ prev_mac) <= 1), 1);
            if (out_bin_vld) begin
                snap_mac[out_bin_idx] = mac_bits;
                snap_w[out_bin_idx] = mel_fbank_weight;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_mac = mac_bits;
            end
        end
        prev_mac = mac_bits;
        prev_ok = rst_n;
    end

    task automatic step(input logic v, input logic [8:0] i, input logic we, input logic [8:0] a, input logic [33:0] d);
        stft_bin_vld = v; stft_bin_idx = i; stft_bin = 16'($urandom);
        cfg_we = we; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 9'd0, 1'b0, 9'd0, 34'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        chk("reset_mac_level", mac_bits, 2'b01);
        rst_n = 1'b1;
    endtask

    task automatic send_frame();
        logic got = 1'b0;
        for (int c = 0; c < 800 && !got; c++) begin
            step(1'b1, m_exp, 1'b0, 9'd0, 34'd0);
            if (frame_done) got = 1'b1;
        end
        chk("frame_done_seen", got, 1'b1);
    endtask

    function automatic logic [33:0] rnd_entry(input int pf);
        logic [1:0] fl;
        fl[1] = ($urandom % pf) == 0;
        fl[0] = ($urandom % pf) == 0;
        return {fl, 16'($urandom), 16'($urandom)};
    endfunction

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(1);
        // Table: MAC1 at 2 and 6, MAC2 at 4 and 8, weight_1 0x4000 at 10
        for (int a = 0; a < 257; a++) begin
            logic [33:0] d;
            d = {2'b00, 16'($urandom), 16'($urandom)};
            if (a == 2 || a == 6) d[33:32] = 2'b10;
            if (a == 4 || a == 8) d[33:32] = 2'b01;
            if (a == 10) d[15:0] = 16'h4000;
            step(1'b0, 9'd0, 1'b1, 9'(a), d);
        end
        step(1'b0, 9'd0, 1'b1, 9'd300, 34'h1234);
        chk("cfg_err_addr300", cfg_err, 1'b1);
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 9'(i), i == 100, 9'd3, 34'h3_ffff_ffff);
            if (i == 100) chk("cfg_err_in_run", cfg_err, 1'b1);
        end
        step(1'b1, 9'd0, 1'b0, 9'd0, 34'd0);
        chk("bin_in_flush_dropped", {out_bin_vld, seq_err}, 2'b01);
        idle(6);
        chk("frame1_done_count", fd_cnt, 1);
        chk("frame1_done_mac", fd_mac, 2'b10);
        chk("mac_at_idx1", snap_mac[1], 2'b01);
        chk("mac_at_idx2", snap_mac[2], 2'b11);
        chk("mac_at_idx4", snap_mac[4], 2'b10);
        chk("mac_at_idx6", snap_mac[6], 2'b00);
        chk("mac_at_idx8", snap_mac[8], 2'b01);
        chk("weight1_at_idx10", snap_w[10][15:0], 16'h4000);
        // Second frame: double flag at 5, gaps and an out-of-order bin
        step(1'b0, 9'd0, 1'b1, 9'd5, {2'b11, 32'h0005_0005});
        step(1'b1, 9'd0, 1'b0, 9'd0, 34'd0);
        step(1'b1, 9'd1, 1'b0, 9'd0, 34'd0);
        idle(3);
        step(1'b1, 9'd3, 1'b0, 9'd0, 34'd0);
        chk("gap_out_of_order", {out_bin_vld, seq_err, mac_bits}, {1'b0, 1'b1, 2'b10});
        for (int i = 2; i <= 5; i++) step(1'b1, 9'(i), 1'b0, 9'd0, 34'd0);
        chk("dbl_mac1_first", {out_bin_vld, out_bin_idx, mac_bits}, {1'b1, 9'd5, 2'b11});
        step(1'b1, 9'd6, 1'b0, 9'd0, 34'd0);
        chk("dbl_mac2_deferred", {out_bin_vld, seq_err, mac_bits}, {1'b0, 1'b1, 2'b10});
        for (int c = 0; c < 50; c++) step(1'b1, m_exp, 1'b0, 9'd0, 34'd0);
        do_reset();
        send_frame();
        idle(2);
        // Random table and random traffic with writes, bad indices and resets
        for (int a = 0; a < 257; a++) step(1'b0, 9'd0, 1'b1, 9'(a), rnd_entry(4));
        for (int c = 0; c < 5000; c++) begin
            if ($urandom % 1500 == 0) do_reset();
            else step(($urandom % 5) != 0,
                      ($urandom % 10 == 0) ? 9'($urandom % 300) : m_exp,
                      ($urandom % 20) == 0,
                      ($urandom % 16 == 0) ? 9'(257 + $urandom % 200) : 9'($urandom % 257),
                      rnd_entry(4));
        end
        send_frame();
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
